// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan controller.
// Holds active-low segment patterns, blanking code and digit enable levels.
package sevenseg_pkg;

  // Digit enables drive PNP/anode switches: low turns a digit on.
  localparam logic DIGIT_ON  = 1'b0;
  localparam logic DIGIT_OFF = 1'b1;

  // All segments dark (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low patterns, bit 0 = a ... bit 6 = g; entry 15 first.
  localparam logic [15:0][6:0] SEG7_HEX = {
    7'h0E, // F
    7'h06, // E
    7'h21, // d
    7'h46, // C
    7'h03, // b
    7'h08, // A
    7'h10, // 9
    7'h00, // 8
    7'h78, // 7
    7'h02, // 6
    7'h12, // 5
    7'h19, // 4
    7'h30, // 3
    7'h24, // 2
    7'h79, // 1
    7'h40  // 0
  };

  function automatic logic [6:0] seg7_hex(
    input logic [3:0] nib
  );
    return SEG7_HEX[nib];
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low a..g pattern.
// Ports: nibble (4-bit hex in), seg_n (7-bit active-low segments out).
module hex_to_seg7
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = seg7_hex(nibble);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed common-anode N-digit display driver
// with per-frame shadow latching, blanking, decimal points and PWM brightness.
// Ports: FPGA_CLK, RST (async, active-high); data_in (4*DIGITS nibbles,
// digit 0 at [3:0]), dp_in, blank_in (per digit), bright (duty level);
// outputs en_seg (active-low digit enables), data_seg (active nibble),
// dt (active-low decimal point), frame_start (shadow load pulse).
// Optional macro SEVENSEG_DECODE_EN adds seg_n[6:0] (active-low a..g).
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50_000,
  parameter int BRIGHT_W = 3
) (
  input  logic                  FPGA_CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     en_seg,
  output logic [3:0]            data_seg,
  output logic                  dt,
`ifdef SEVENSEG_DECODE_EN
  output logic [6:0]            seg_n,
`endif
  output logic                  frame_start
);

  localparam int CW   = $clog2(SCAN_DIV);
  localparam int IW   = $clog2(DIGITS);
  localparam int UNIT = SCAN_DIV >> BRIGHT_W;

  localparam logic [CW-1:0]       CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]       IDX_MAX = IW'(DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] BR_FULL = '1;

  if (DIGITS < 2 || SCAN_DIV < (1 << BRIGHT_W)) begin : g_bad_cfg
    $fatal(1, "sevenseg_scan_ctrl: need DIGITS>=2, SCAN_DIV>=2**BRIGHT_W");
  end

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                load_pend;
  logic [4*DIGITS-1:0] data_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [DIGITS-1:0]   blank_sh;
  logic [BRIGHT_W-1:0] bright_sh;

  logic                slot_tick;
  logic                frame_wrap;
  logic                load;
  logic [3:0]          nib;
  logic [31:0]         on_len;
  logic                lit;
  logic [DIGITS-1:0]   en_nxt;

  assign slot_tick  = (cnt == CNT_MAX);
  assign frame_wrap = slot_tick && (idx == IDX_MAX);
  assign load       = load_pend || frame_wrap;

  // load_pend marks the first edge after reset: the shadow loads there
  // while the scan position holds at slot 0 so the first frame is as long
  // as every later one.
  always_ff @(posedge FPGA_CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      idx       <= '0;
      load_pend <= 1'b1;
      data_sh   <= '0;
      dp_sh     <= '0;
      blank_sh  <= '0;
      bright_sh <= '0;
    end else begin
      load_pend <= 1'b0;
      if (load) begin
        data_sh   <= data_in;
        dp_sh     <= dp_in;
        blank_sh  <= blank_in;
        bright_sh <= bright;
      end
      if (!load_pend) begin
        cnt <= slot_tick ? '0 : cnt + CW'(1);
        if (slot_tick) begin
          idx <= frame_wrap ? '0 : idx + IW'(1);
        end
      end
    end
  end

  assign nib    = data_sh[{idx, 2'b00} +: 4];
  assign on_len = 32'(bright_sh) * 32'(UNIT);

  // bright_sh == 0 gives on_len == 0, so the digit never lights.
  assign lit = !blank_sh[idx] &&
               ((bright_sh == BR_FULL) || (32'(cnt) < on_len));

  always_comb begin
    en_nxt = {DIGITS{DIGIT_OFF}};
    if (lit) begin
      en_nxt[idx] = DIGIT_ON;
    end
  end

  always_ff @(posedge FPGA_CLK or posedge RST) begin
    if (RST) begin
      en_seg      <= {DIGITS{DIGIT_OFF}};
      data_seg    <= '0;
      dt          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      en_seg      <= en_nxt;
      data_seg    <= nib;
      dt          <= lit ? ~dp_sh[idx] : 1'b1;
      frame_start <= load;
    end
  end

`ifdef SEVENSEG_DECODE_EN
  logic [6:0] seg_pat;

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nib),
    .seg_n  (seg_pat)
  );

  always_ff @(posedge FPGA_CLK or posedge RST) begin
    if (RST) begin
      seg_n <= SEG_OFF;
    end else begin
      seg_n <= lit ? seg_pat : SEG_OFF;
    end
  end
`endif

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl (DIGITS=4, SCAN_DIV=16, BRIGHT_W=3).
// k counts clock edges since reset release; outputs sampled on negedge.
`timescale 1ns/1ps
module tb_sevenseg_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 16;
  localparam int BRIGHT_W = 3;

  logic                FPGA_CLK = 1'b0;
  logic                RST      = 1'b0;
  logic [15:0]         data_in  = 16'h4321;
  logic [3:0]          dp_in    = 4'b0000;
  logic [3:0]          blank_in = 4'b0000;
  logic [2:0]          bright   = 3'd7;
  logic [3:0]          en_seg;
  logic [3:0]          data_seg;
  logic                dt;
  logic                frame_start;
`ifdef SEVENSEG_DECODE_EN
  logic [6:0]          seg_n;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  always #5 FPGA_CLK = ~FPGA_CLK;

  sevenseg_scan_ctrl #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BRIGHT_W (BRIGHT_W)
  ) dut (
    .FPGA_CLK    (FPGA_CLK),
    .RST         (RST),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .bright      (bright),
    .en_seg      (en_seg),
    .data_seg    (data_seg),
    .dt          (dt),
`ifdef SEVENSEG_DECODE_EN
    .seg_n       (seg_n),
`endif
    .frame_start (frame_start)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge FPGA_CLK);
    @(negedge FPGA_CLK);
    k += n;
  endtask

  task automatic goto(input int t);
    step(t - k);
  endtask

  task automatic do_reset(input logic [15:0] d, input logic [3:0] dp,
                          input logic [3:0] bl, input logic [2:0] br);
    RST      = 1'b1;
    data_in  = d;
    dp_in    = dp;
    blank_in = bl;
    bright   = br;
    @(posedge FPGA_CLK);
    @(negedge FPGA_CLK);
    RST = 1'b0;
    @(posedge FPGA_CLK);
    @(negedge FPGA_CLK);
    k = 0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_e, c_d, c_b, c_7, c_f, c_x, c_fs, c_dt0, c_dtbad;

    #1 RST = 1'b1;
    #1;
    chk("rst_en", en_seg, 4'hF);
    chk("rst_data", data_seg, 4'h0);
    chk("rst_dt", dt, 1'b1);
    chk("rst_fs", frame_start, 1'b0);
`ifdef SEVENSEG_DECODE_EN
    chk("rst_seg", seg_n, 7'h7F);
`endif

    // Scan order, tear-free data update
    do_reset(16'h4321, 4'b0000, 4'b0000, 3'd7);
    chk("p1_fs0", frame_start, 1'b1);
    chk("p1_en0", en_seg, 4'hF);
    step(1);
    chk("p1_en1", en_seg, 4'b1110);
    chk("p1_d1", data_seg, 4'h1);
    chk("p1_dt1", dt, 1'b1);
    chk("p1_fs1", frame_start, 1'b0);
    goto(16);
    chk("p1_en16", en_seg, 4'b1110);
    goto(17);
    chk("p1_en17", en_seg, 4'b1101);
    chk("p1_d17", data_seg, 4'h2);
    goto(20);
    data_in = 16'h8765;
    goto(33);
    chk("p2_en33", en_seg, 4'b1011);
    chk("p2_d33", data_seg, 4'h3);
    goto(49);
    chk("p2_en49", en_seg, 4'b0111);
    chk("p2_d49", data_seg, 4'h4);
    goto(63);
    chk("p2_fs63", frame_start, 1'b0);
    goto(64);
    chk("p2_fs64", frame_start, 1'b1);
    chk("p2_d64", data_seg, 4'h4);
    goto(65);
    chk("p2_en65", en_seg, 4'b1110);
    chk("p2_d65", data_seg, 4'h5);
    goto(81);
    chk("p2_d81", data_seg, 4'h6);
    goto(97);
    chk("p2_d97", data_seg, 4'h7);
    goto(113);
    chk("p2_en113", en_seg, 4'b0111);
    chk("p2_d113", data_seg, 4'h8);
    goto(128);
    chk("p2_fs128", frame_start, 1'b1);
    c_e = 0; c_d = 0; c_b = 0; c_7 = 0; c_f = 0; c_x = 0; c_fs = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (frame_start) c_fs++;
      case (en_seg)
        4'b1110: c_e++;
        4'b1101: c_d++;
        4'b1011: c_b++;
        4'b0111: c_7++;
        4'b1111: c_f++;
        default: c_x++;
      endcase
    end
    chk("full_e", c_e, 16);
    chk("full_d", c_d, 16);
    chk("full_b", c_b, 16);
    chk("full_7", c_7, 16);
    chk("full_dark", c_f, 0);
    chk("full_bad", c_x, 0);
    chk("full_fs", c_fs, 1);

    // Brightness 2 of 7: lit for cnt 0..3 only
    do_reset(16'h4321, 4'b0000, 4'b0000, 3'd2);
    step(1);
    chk("br2_k1", en_seg, 4'b1110);
    goto(4);
    chk("br2_k4", en_seg, 4'b1110);
    goto(5);
    chk("br2_k5", en_seg, 4'b1111);
    goto(17);
    chk("br2_k17", en_seg, 4'b1101);
    goto(21);
    chk("br2_k21", en_seg, 4'b1111);
    goto(64);
    c_e = 0; c_d = 0; c_b = 0; c_7 = 0; c_f = 0; c_x = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      case (en_seg)
        4'b1110: c_e++;
        4'b1101: c_d++;
        4'b1011: c_b++;
        4'b0111: c_7++;
        4'b1111: c_f++;
        default: c_x++;
      endcase
    end
    chk("br2_e", c_e, 4);
    chk("br2_d", c_d, 4);
    chk("br2_b", c_b, 4);
    chk("br2_7", c_7, 4);
    chk("br2_dark", c_f, 48);
    chk("br2_bad", c_x, 0);

    // Brightness 0: never lit
    do_reset(16'h4321, 4'b0000, 4'b0000, 3'd0);
    c_x = 0; c_fs = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (en_seg != 4'b1111) c_x++;
      if (frame_start) c_fs++;
    end
    chk("br0_lit", c_x, 0);
    chk("br0_fs", c_fs, 1);

    // Blank digit 2, decimal point on digit 0
    do_reset(16'h4321, 4'b0001, 4'b0100, 3'd7);
    c_b = 0; c_f = 0; c_dt0 = 0; c_dtbad = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (en_seg == 4'b1011) c_b++;
      if (en_seg == 4'b1111) c_f++;
      if (dt == 1'b0) c_dt0++;
      if (dt == 1'b0 && en_seg != 4'b1110) c_dtbad++;
    end
    chk("blk_d2", c_b, 0);
    chk("blk_dark", c_f, 16);
    chk("dp_low", c_dt0, 16);
    chk("dp_bad", c_dtbad, 0);

    // Asynchronous reset mid-frame at idx=2, cnt=9
    do_reset(16'h4321, 4'b0000, 4'b0000, 3'd7);
    goto(41);
    chk("mr_en_pre", en_seg, 4'b1011);
    chk("mr_d_pre", data_seg, 4'h3);
    RST = 1'b1;
    #1;
    chk("mr_en", en_seg, 4'hF);
    chk("mr_data", data_seg, 4'h0);
    chk("mr_dt", dt, 1'b1);
    chk("mr_fs", frame_start, 1'b0);
    @(posedge FPGA_CLK);
    #1;
    chk("mr_en_hold", en_seg, 4'hF);
    @(negedge FPGA_CLK);
    RST = 1'b0;
    @(posedge FPGA_CLK);
    @(negedge FPGA_CLK);
    k = 0;
    chk("mr_fs_post", frame_start, 1'b1);
    step(1);
    chk("mr_en1", en_seg, 4'b1110);
    chk("mr_d1", data_seg, 4'h1);
    goto(17);
    chk("mr_en17", en_seg, 4'b1101);

`ifdef SEVENSEG_DECODE_EN
    do_reset(16'h4320, 4'b0000, 4'b0000, 3'd2);
    chk("seg_k0", seg_n, 7'h7F);
    step(1);
    chk("seg_zero", seg_n, 7'b1000000);
    goto(5);
    chk("seg_dark", seg_n, 7'h7F);
    goto(17);
    chk("seg_two", seg_n, 7'b0100100);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Parametrised time-multiplexed driver for a common-anode N-digit seven-segment display. It sits between the datapath that produces per-digit BCD/hex nibbles and the board display pins. It scans DIGITS digits at a programmable slot rate and latches input data once per frame so the display never shows a torn value. It adds per-digit blanking, per-digit decimal point and PWM brightness.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (≥ 2)
- SCAN_DIV, 50_000, clock cycles per digit slot (1 kHz slot at 50 MHz FPGA_CLK); must be ≥ 2**BRIGHT_W
- BRIGHT_W, 3, width of brightness control

Ports:
- Clocking and reset: one clock, FPGA_CLK; reset RST is asynchronous and active-high.
- FPGA_CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- data_in  in  4*DIGITS  digit nibbles; digit k at [4k+3:4k], digit 0 rightmost
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit
- blank_in  in  DIGITS  1 = digit k dark for the whole frame
- bright  in  BRIGHT_W  duty level; 0 = dark, all-ones = full slot
- en_seg  out  DIGITS  digit enables, active-low, at most one bit low
- data_seg  out  4  nibble of the active digit
- dt  out  1  decimal point, active-low
- frame_start  out  1  one-cycle pulse when a new frame's shadow data is loaded

## Operation
- Prescaler cnt counts 0..SCAN_DIV-1 and wraps. slot_tick = (cnt == SCAN_DIV-1).
- Digit index idx advances on slot_tick, 0..DIGITS-1, then wraps to 0.
- Shadow registers hold data, dp, blank and bright. They load from the inputs when idx wraps DIGITS-1→0, and on the first FPGA_CLK edge after RST deasserts. frame_start pulses in the same cycle as the load.
- Inputs are ignored between loads. Changes mid-frame take effect at the next frame.
- on_len = bright_sh * (SCAN_DIV >> BRIGHT_W). The digit is lit when cnt < on_len, or when bright_sh is all-ones (full slot). If bright_sh = 0, the digit is never lit.
- Lit: en_seg = ~(1 << idx), data_seg = nibble[idx], dt = ~dp_sh[idx].
- Dark (blank_sh[idx], outside the on window, or bright 0): en_seg all ones, data_seg holds nibble[idx], dt = 1.

## Timing
- All outputs are registered. They reflect idx/cnt one cycle after the internal state.
- Reset values: en_seg all ones, data_seg 0, dt 1, frame_start 0, cnt 0, idx 0, shadow registers 0.
- RST asserted mid-frame: all outputs go to their reset values immediately (asynchronous). Scanning restarts at digit 0 with a fresh load.
- Frame period: DIGITS*SCAN_DIV cycles. frame_start spacing is exactly that.
- Digit-to-digit switch: en_seg changes in a single cycle, with no overlap of two low bits.
- Simultaneous slot_tick and frame wrap: the load and the index change land in the same edge. Digit 0 of the new frame uses the new shadow data.

## Configuration
- SEVENSEG_DECODE_EN, when defined:
  - Adds output seg_n[6:0], active-low a..g, decoded from data_seg's source nibble (hex 0–F), registered in the same stage.
  - seg_n is all ones whenever the digit is dark.
- Without the macro:
  - seg_n does not exist.
  - data_seg carries the raw nibble for an external decoder.

## Structure
- Package sevenseg_pkg holds:
  - the 16-entry SEG7_HEX active-low pattern constants
  - SEG_OFF = 7'h7F
  - the DIGIT_OFF convention (enables active-low)
- Sub-module hex_to_seg7: combinational nibble → active-low pattern. It is instantiated only under SEVENSEG_DECODE_EN.
- Elaboration check: SCAN_DIV ≥ 2**BRIGHT_W and DIGITS ≥ 2; otherwise a fatal error.

## Test plan
- DIGITS=4, SCAN_DIV=16, data_in=16'h4321, bright=7, no blank:
  - en_seg cycles 1110,1101,1011,0111, 16 cycles each.
  - data_seg follows 1,2,3,4.
  - frame_start every 64 cycles.
- data_in changed from 16'h4321 to 16'h8765 while idx=1: digits 2–3 still show 3,4. Values 5..8 appear only after the next frame_start.
- bright=2, SCAN_DIV=16, BRIGHT_W=3: each digit's en_seg is low for exactly 4 cycles per slot. bright=0: en_seg stays all ones.
- blank_in=4'b0100, dp_in=4'b0001: digit 2 is never enabled. dt=0 only while en_seg=1110.
- RST pulsed for 1 cycle at idx=2, cnt=9:
  - All outputs are at reset values during the pulse.
  - Scanning resumes at digit 0, with frame_start on the first post-reset edge.
- SEVENSEG_DECODE_EN defined, data_in nibble 4'h0 on the active digit: seg_n = 7'b1000000 while lit, 7'h7F when dark.
